keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 matrix keypad, synchronizes and debounces the row lines, and produces the `key`/`released` pair that the calculator front end consumes. It drives one column low at a time, locks onto the first closed switch found, and holds the decoded 4-bit code stable. `released` is high whenever no key is held. It sits between the board keypad pins and the calculator's key filter/state logic, replacing the raw switch inputs.

## Interface
- `SCAN_DIV`, default 1000: clock cycles each column is driven; must be ≥ 2.
- `DEBOUNCE`, default 50000: consecutive stable cycles required to accept a press or a release; must be ≥ 1.
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  synchronous, active-high reset.
- `row_n`  in  4  keypad rows, active-low, externally pulled up, asynchronous to `clk`.
- `col_n`  out  4  column drive, active-low, exactly one bit low at any time.
- `key`  out  4  code of the most recently accepted key; stable between accepted presses.
- `released`  out  1  high when no key is held (debounced); low from press acceptance until release acceptance.
- `strobe`  out  1  one-cycle pulse on release acceptance; marks a complete keystroke.

## Operation
- Rows pass through a 2-flop synchronizer; all logic uses the synchronized `rows` only.
- Key map, indexed by [row][col]:
  - Row 0: 1 2 3 A
  - Row 1: 4 5 6 B
  - Row 2: 7 8 9 C
  - Row 3: `*`=E, 0, `#`=F, D
- If several rows are low, the lowest row index wins. Only the active column is considered.
- FSM states:
  - SCAN
    - `col_n` rotates 1110→1101→1011→0111→1110, advancing every `SCAN_DIV` cycles.
    - Rows are sampled only on the last cycle of each column window, which allows settling time.
    - If any row is low at sampling, latch `cand_row`/`cand_col`, freeze the column and go to DB_PRESS. Otherwise advance the column.
  - DB_PRESS
    - Column stays frozen. Count cycles with `rows[cand_row]`=0.
    - If that row goes high, clear the counter and return to SCAN at the next column.
    - When the count reaches `DEBOUNCE`: `key`←map[cand_row][cand_col], `released`←0, go to HELD.
  - HELD
    - Column stays frozen. When `rows[cand_row]`=1, go to DB_RELEASE with the counter cleared.
    - A second key pressed while one is held is ignored.
  - DB_RELEASE
    - Count cycles with `rows[cand_row]`=1.
    - If that row goes low, return to HELD.
    - When the count reaches `DEBOUNCE`: `released`←1, `strobe`←1 for one cycle, go to SCAN with the column reset to 0 and the divider cleared.
- Reset values: state SCAN, `col_n`=1110, `key`=0, `released`=1, `strobe`=0, all counters 0, synchronizer flops all 1.
- Reset asserted mid-press or mid-debounce takes priority: all of the above values apply on the next edge, and no `strobe` is issued.
- Counter widths: `$clog2(SCAN_DIV)` and `$clog2(DEBOUNCE+1)`. Counters never wrap while in a debounce state.

## Timing
- Pin-to-`rows` latency: 2 cycles.
- Press acceptance: `key`/`released` update on the clock edge where the debounce count reaches `DEBOUNCE`, i.e. `DEBOUNCE` cycles after entering DB_PRESS.
- Worst-case detection from a synchronized press to DB_PRESS entry: 4·`SCAN_DIV` cycles.
- `key` and `released` change in the same cycle.
- `strobe` is asserted in the same cycle `released` rises and is low in all other cycles.
- `col_n` changes only at a window boundary, or on SCAN re-entry after a release.

## Structure
- Package `keypad_pkg` holds:
  - the state enum `kp_state_t` (SCAN, DB_PRESS, HELD, DB_RELEASE);
  - the 4x4 key-map constant `KEYMAP[4][4]` of 4-bit codes;
  - the column reset constant `COL_INIT`=4'b1110.
- One sub-module, `row_sync`: a 4-bit 2-flop synchronizer with reset value 1111.
- All other logic stays in `keypad_scanner`.

## Test plan
All scenarios use `SCAN_DIV`=4 and `DEBOUNCE`=8.
- Reset, no keys pressed → `col_n` cycles 1110,1101,1011,0111 with 4 cycles each; `released`=1, `key`=0, `strobe` never asserted.
- Hold row 1 / col 2 ("6") low → within 16+2+8 cycles `key`=6 and `released`=0. Release it → exactly 8 synchronized-high cycles later `released`=1 with a single `strobe` pulse.
- Bounce: row toggles every 3 cycles during DB_PRESS → never accepted; state returns to SCAN and `released` stays 1.
- Press "7" (row 2, col 0) and "*" (row 3, col 0) together → `key`=7.
- While "7" is held, additionally press "5" → `key` stays 7. Release both → one `strobe`.
- Assert `reset` in HELD with `key`=B → next cycle `key`=0, `released`=1, `col_n`=1110, `strobe`=0.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanner.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN       = 2'd0,
      DB_PRESS   = 2'd1,
      HELD       = 2'd2,
      DB_RELEASE = 2'd3
   } kp_state_t;

   // Key codes indexed [row][col]; '*' and '#' map to E and F.
   localparam logic [3:0] KEYMAP [4][4] = '{
      '{4'h1, 4'h2, 4'h3, 4'hA},
      '{4'h4, 4'h5, 4'h6, 4'hB},
      '{4'h7, 4'h8, 4'h9, 4'hC},
      '{4'hE, 4'h0, 4'hF, 4'hD}
   };

   localparam logic [3:0] COL_INIT = 4'b1110;

   // Lowest-indexed low row; only meaningful when at least one row is low.
   function automatic logic [1:0] low_row_idx(input logic [3:0] rows);
      if (!rows[0]) return 2'd0;
      if (!rows[1]) return 2'd1;
      if (!rows[2]) return 2'd2;
      return 2'd3;
   endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the active-low keypad row pins.
module row_sync (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [3:0] rows
);

   logic [3:0] rows_p0;

   always_ff @(posedge clk) begin
      if (reset) begin
         rows_p0 <= 4'hF;
         rows    <= 4'hF;
      end else begin
         rows_p0 <= row_n;
         rows    <= rows_p0;
      end
   end

endmodule

// File: rtl/keypad_scanner.sv
// Column-scanning 4x4 keypad front end: locks onto the first closed switch,
// debounces press and release, and presents a stable key code.
module keypad_scanner
   import keypad_pkg::*;
#(
   parameter int SCAN_DIV = 1000,
   parameter int DEBOUNCE = 50000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] row_n,
   output logic [3:0] col_n,
   output logic [3:0] key,
   output logic       released,
   output logic       strobe
);

   localparam int DIV_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam int DB_W  = $clog2(DEBOUNCE + 1);
   localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
   localparam logic [DB_W-1:0]  DB_DONE  = DB_W'(DEBOUNCE);

   logic [3:0]       rows;
   kp_state_t        state, state_nx;
   logic [DIV_W-1:0] div, div_nx;
   logic [DB_W-1:0]  db, db_nx, db_inc;
   logic [1:0]       col, col_nx;
   logic [3:0]       col_n_nx;
   logic [1:0]       cand_row, cand_row_nx;
   logic [1:0]       cand_col, cand_col_nx;
   logic [3:0]       key_nx;
   logic             released_nx, strobe_nx;
   logic             cand_high;

   row_sync u_row_sync (
      .clk   (clk),
      .reset (reset),
      .row_n (row_n),
      .rows  (rows)
   );

   assign db_inc    = db + 1'b1;
   assign cand_high = rows[cand_row];

   always_ff @(posedge clk) begin
      if (reset) begin
         state    <= SCAN;
         div      <= '0;
         db       <= '0;
         col      <= '0;
         col_n    <= COL_INIT;
         cand_row <= '0;
         cand_col <= '0;
         key      <= '0;
         released <= 1'b1;
         strobe   <= 1'b0;
      end else begin
         state    <= state_nx;
         div      <= div_nx;
         db       <= db_nx;
         col      <= col_nx;
         col_n    <= col_n_nx;
         cand_row <= cand_row_nx;
         cand_col <= cand_col_nx;
         key      <= key_nx;
         released <= released_nx;
         strobe   <= strobe_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      div_nx      = div;
      db_nx       = db;
      col_nx      = col;
      col_n_nx    = col_n;
      cand_row_nx = cand_row;
      cand_col_nx = cand_col;
      key_nx      = key;
      released_nx = released;
      strobe_nx   = 1'b0;

      case (state)
         SCAN: begin
            // Rows are only trusted on the last cycle of a column window.
            if (div == DIV_LAST) begin
               if (rows != 4'hF) begin
                  cand_row_nx = low_row_idx(rows);
                  cand_col_nx = col;
                  db_nx       = '0;
                  state_nx    = DB_PRESS;
               end else begin
                  div_nx   = '0;
                  col_nx   = col + 2'd1;
                  col_n_nx = {col_n[2:0], col_n[3]};
               end
            end else begin
               div_nx = div + 1'b1;
            end
         end
         DB_PRESS: begin
            if (!cand_high) begin
               db_nx = db_inc;
               if (db_inc == DB_DONE) begin
                  key_nx      = KEYMAP[cand_row][cand_col];
                  released_nx = 1'b0;
                  db_nx       = '0;
                  state_nx    = HELD;
               end
            end else begin
               db_nx    = '0;
               div_nx   = '0;
               col_nx   = col + 2'd1;
               col_n_nx = {col_n[2:0], col_n[3]};
               state_nx = SCAN;
            end
         end
         HELD: begin
            if (cand_high) begin
               db_nx    = '0;
               state_nx = DB_RELEASE;
            end
         end
         DB_RELEASE: begin
            if (cand_high) begin
               db_nx = db_inc;
               if (db_inc == DB_DONE) begin
                  released_nx = 1'b1;
                  strobe_nx   = 1'b1;
                  db_nx       = '0;
                  div_nx      = '0;
                  col_nx      = '0;
                  col_n_nx    = COL_INIT;
                  state_nx    = SCAN;
               end
            end else begin
               state_nx = HELD;
            end
         end
         default: state_nx = SCAN;
      endcase
   end

endmodule

// File: tb/tb_keypad_scanner.sv
// Bench for keypad_scanner: emulated key matrix, abstract behavioural model
// checked every cycle, and directed scenarios with literal expectations.
module tb_keypad_scanner;

   localparam int SD = 4;
   localparam int DB = 8;

   logic       clk;
   logic       reset;
   logic [3:0] row_n;
   logic [3:0] col_n;
   logic [3:0] key;
   logic       released;
   logic       strobe;

   logic [15:0] pressed;   // bit r*4+c closes switch at row r, column c

   int n_vec = 0;
   int n_err = 0;
   int n_strobe = 0;

   // model state
   bit         m_live = 0;
   int         m_pos = 0;  // position within the 4*SD scan cycle
   bit         m_locked, m_down;
   int         m_cr, m_cc, m_low, m_high;
   logic [3:0] m_key;
   logic       m_rel, m_strobe;
   logic [3:0] m_s1 = 4'hF, m_s2 = 4'hF;
   logic [3:0] rn, ecol;

   keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE(DB)) dut (
      .clk      (clk),
      .reset    (reset),
      .row_n    (row_n),
      .col_n    (col_n),
      .key      (key),
      .released (released),
      .strobe   (strobe)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic logic [3:0] pins(input logic [15:0] p, input int c);
      logic [3:0] r;
      for (int i = 0; i < 4; i++) r[i] = ~p[i*4 + c];
      return r;
   endfunction

   function automatic logic [3:0] tb_map(input int r, input int c);
      case (r*4 + c)
         0: return 4'h1;  1: return 4'h2;  2: return 4'h3;  3: return 4'hA;
         4: return 4'h4;  5: return 4'h5;  6: return 4'h6;  7: return 4'hB;
         8: return 4'h7;  9: return 4'h8; 10: return 4'h9; 11: return 4'hC;
         12: return 4'hE; 13: return 4'h0; 14: return 4'hF; default: return 4'hD;
      endcase
   endfunction

   function automatic int lowest(input logic [3:0] r);
      for (int i = 0; i < 4; i++) if (!r[i]) return i;
      return 0;
   endfunction

   // The keypad answers whatever column the model says is being driven.
   assign row_n = pins(pressed, m_pos / SD);

   task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      rn = row_n;
      m_strobe = 1'b0;
      if (reset) begin
         m_live = 1; m_pos = 0; m_locked = 0; m_down = 0;
         m_key = 4'h0; m_rel = 1'b1; m_low = 0; m_high = 0;
         m_s1 = 4'hF; m_s2 = 4'hF;
      end else if (m_live) begin
         if (!m_locked) begin
            if ((m_pos % SD == SD - 1) && (m_s2 != 4'hF)) begin
               m_locked = 1; m_cc = m_pos / SD; m_cr = lowest(m_s2); m_low = 0;
            end else begin
               m_pos = (m_pos + 1) % (4*SD);
            end
         end else if (!m_down) begin
            if (!m_s2[m_cr]) begin
               m_low++;
               if (m_low == DB) begin
                  m_down = 1; m_key = tb_map(m_cr, m_cc); m_rel = 1'b0; m_high = 0;
               end
            end else begin
               m_locked = 0; m_pos = ((m_cc + 1) % 4) * SD;
            end
         end else begin
            // A release needs one high cycle to leave HELD plus DB counted ones.
            if (m_s2[m_cr]) begin
               m_high++;
               if (m_high == DB + 1) begin
                  m_rel = 1'b1; m_strobe = 1'b1; m_down = 0; m_locked = 0; m_pos = 0;
               end
            end else begin
               m_high = 0;
            end
         end
         m_s2 = m_s1;
         m_s1 = rn;
      end
      if (m_live) begin
         ecol = 4'b0001 << (m_pos / SD);
         ecol = ~ecol;
         chk("model_col_n", {4'h0, col_n}, {4'h0, ecol});
         chk("model_key", {4'h0, key}, {4'h0, m_key});
         chk("model_released", {7'h0, released}, {7'h0, m_rel});
         chk("model_strobe", {7'h0, strobe}, {7'h0, m_strobe});
         if (strobe === 1'b1) n_strobe++;
      end
   end

   task automatic wait_rel(input string nm, input logic want, input int lim, output int k);
      k = 0;
      while (k < lim) begin
         @(posedge clk); #2;
         k++;
         if (released === want) break;
      end
      chk(nm, {7'h0, released}, {7'h0, want});
   endtask

   int k, s0;
   logic [3:0] exp_col;

   initial begin
      reset = 1'b1;
      pressed = 16'h0;
      repeat (3) @(negedge clk);
      chk("rst_key", {4'h0, key}, 8'h00);
      chk("rst_released", {7'h0, released}, 8'h01);
      chk("rst_col_n", {4'h0, col_n}, 8'h0E);
      chk("rst_strobe", {7'h0, strobe}, 8'h00);

      // Idle scan: four cycles per column, starting at column 0.
      reset = 1'b0;
      for (int i = 1; i <= 16; i++) begin
         @(posedge clk); #2;
         exp_col = 4'b0001 << ((i / 4) % 4);
         exp_col = ~exp_col;
         chk("idle_col_n", {4'h0, col_n}, {4'h0, exp_col});
      end
      chk("idle_strobes", 8'(n_strobe), 8'd0);

      // "6" at row 1, column 2.
      @(negedge clk);
      pressed = 16'h0040;
      wait_rel("press6_wait", 1'b0, 40, k);
      chk("press6_latency_ok", {7'h0, k <= 26}, 8'h01);
      chk("press6_key", {4'h0, key}, 8'h06);
      repeat (5) @(negedge clk);
      pressed = 16'h0;
      s0 = n_strobe;
      wait_rel("release6_wait", 1'b1, 40, k);
      chk("release6_edges", 8'(k), 8'd11);
      chk("release6_strobe", {7'h0, strobe}, 8'h01);
      repeat (6) @(negedge clk);
      chk("release6_one_strobe", 8'(n_strobe - s0), 8'd1);

      // Bouncing "5": no run of low cycles is ever long enough.
      for (int i = 0; i < 60; i++) begin
         @(negedge clk);
         if (i % 3 == 0) pressed = pressed ^ 16'h0020;
         if (i % 6 == 0) chk("bounce_released", {7'h0, released}, 8'h01);
      end
      pressed = 16'h0;
      repeat (20) @(negedge clk);
      chk("bounce_after_released", {7'h0, released}, 8'h01);

      // "7" and "*" share column 0; the lower row wins.
      pressed = 16'h1100;
      wait_rel("press7_wait", 1'b0, 40, k);
      chk("press7_key", {4'h0, key}, 8'h07);
      @(negedge clk);
      pressed = pressed | 16'h0020;
      repeat (20) @(negedge clk);
      chk("second_key_ignored", {4'h0, key}, 8'h07);
      chk("second_key_held", {7'h0, released}, 8'h00);
      s0 = n_strobe;
      pressed = 16'h0;
      repeat (30) @(negedge clk);
      chk("release_both_strobes", 8'(n_strobe - s0), 8'd1);
      chk("release_both_released", {7'h0, released}, 8'h01);

      // Reset while "B" is held.
      pressed = 16'h0080;
      wait_rel("pressB_wait", 1'b0, 40, k);
      chk("pressB_key", {4'h0, key}, 8'h0B);
      @(negedge clk);
      reset = 1'b1;
      pressed = 16'h0;
      @(posedge clk); #2;
      chk("midreset_key", {4'h0, key}, 8'h00);
      chk("midreset_released", {7'h0, released}, 8'h01);
      chk("midreset_col_n", {4'h0, col_n}, 8'h0E);
      chk("midreset_strobe", {7'h0, strobe}, 8'h00);
      @(negedge clk);
      s0 = n_strobe;
      reset = 1'b0;
      repeat (20) @(negedge clk);
      chk("post_reset_no_strobe", 8'(n_strobe - s0), 8'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
